// File: rtl/gray_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_counter_pkg : shared types and Gray-code helpers for gray_counter      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package gray_counter_pkg;

    localparam int c_FN_W = 32;

    // Next-state action chosen each edge, in priority order load > en > hold.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_STEP  = 2'd2,
        ACT_BOUND = 2'd3
    } act_e;

    function automatic logic [c_FN_W-1:0] bin2gray(input logic [c_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [c_FN_W-1:0] gray2bin(input logic [c_FN_W-1:0] g);
        logic [c_FN_W-1:0] b;
        logic              par;
        b   = '0;
        par = 1'b0;
        for (int i = c_FN_W - 1; i >= 0; i--) begin
            par  = par ^ g[i];
            b[i] = par;
        end
        return b;
    endfunction

    function automatic logic [c_FN_W-1:0] gray_max(input int n);
        if (n >= c_FN_W) return '1;
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_counter_if : control inputs and count outputs of gray_counter          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface gray_counter_if #(
    parameter int N = 8
);
    logic         en;
    logic         up;
    logic         load;
    logic         load_gray;
    logic [N-1:0] load_val;
    logic [N-1:0] binary;
    logic [N-1:0] gray;
    logic         wrap;
    logic         at_max;
    logic         at_min;

    modport master (
        output en, up, load, load_gray, load_val,
        input  binary, gray, wrap, at_max, at_min
    );

    modport slave (
        input  en, up, load, load_gray, load_val,
        output binary, gray, wrap, at_max, at_min
    );
endinterface
`default_nettype wire

// File: rtl/gray_counter_gry_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gry_bin : combinational Gray-to-binary converter (prefix XOR from the MSB)  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module gry_bin #(
    parameter int N = 8
) (
    input  wire logic [N-1:0] gray,
    output logic      [N-1:0] bin
);
    logic w_par;

    always_comb begin
        bin   = '0;
        w_par = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            w_par  = w_par ^ gray[i];
            bin[i] = w_par;
        end
    end
endmodule
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_counter : N-bit up/down counter with registered binary and Gray       |
// | outputs, binary/Gray load, wrap or saturate mode and a boundary pulse.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int N       = 8,
    parameter int WRAP    = 1,
    parameter int RST_VAL = 0
) (
    input wire logic     clk,
    input wire logic     rst,
    gray_counter_if.slave bus
);
    localparam logic [N-1:0] c_MAX      = N'(gray_max(N));
    localparam logic [N-1:0] c_ONE      = N'(1);
    localparam logic [N-1:0] c_RST_BIN  = N'(RST_VAL);
    localparam logic [N-1:0] c_RST_GRAY = N'(bin2gray(32'(RST_VAL)));

    logic [N-1:0] r_bin;
    logic [N-1:0] r_gray;
    logic         r_wrap;

    logic [N-1:0] w_load_bin;
    logic [N-1:0] w_bin_nxt;
    logic [N-1:0] w_gray_nxt;
    logic         w_wrap_nxt;
    logic         w_at_max;
    logic         w_at_min;
    act_e         w_act;

    gry_bin #(.N(N)) u_gry_bin (
        .gray (bus.load_val),
        .bin  (w_load_bin)
    );

    assign w_at_max = (r_bin == c_MAX);
    assign w_at_min = (r_bin == '0);

    always_comb begin
        w_act = ACT_HOLD;
        if (bus.load)
            w_act = ACT_LOAD;
        else if (bus.en && ((bus.up && w_at_max) || (!bus.up && w_at_min)))
            w_act = ACT_BOUND;
        else if (bus.en)
            w_act = ACT_STEP;
    end

    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        case (w_act)
            ACT_LOAD:  w_bin_nxt = bus.load_gray ? w_load_bin : bus.load_val;
            ACT_STEP:  w_bin_nxt = bus.up ? (r_bin + c_ONE) : (r_bin - c_ONE);
            ACT_BOUND: begin
                w_wrap_nxt = 1'b1;
                // Saturating mode leaves the count where it is.
                if (WRAP != 0)
                    w_bin_nxt = bus.up ? '0 : c_MAX;
            end
            default:   w_bin_nxt = r_bin;
        endcase
    end

    // Gray is encoded from the next binary value so both registers stay aligned.
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= c_RST_BIN;
            r_gray <= c_RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.binary = r_bin;
    assign bus.gray   = r_gray;
    assign bus.wrap   = r_wrap;
    assign bus.at_max = w_at_max;
    assign bus.at_min = w_at_min;
endmodule
`default_nettype wire
